sb_dsp_dma: RTL and testbench



---
 rtl/sb_pkg.sv | 35 +++
 rtl/sb_dsp_dma_if.sv | 26 ++
 rtl/sb_rd_queue.sv | 53 +++++
 rtl/sb_dsp_dma.sv | 183 ++++++++++++++++++
 tb/tb_sb_dsp_dma.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared constants and types for the Sound Blaster DSP front end.
package sb_pkg;

    // Port offsets from BASE
    localparam logic [3:0] OFF_RST  = 4'h6;
    localparam logic [3:0] OFF_DATA = 4'hA;
    localparam logic [3:0] OFF_CMD  = 4'hC;
    localparam logic [3:0] OFF_STAT = 4'hE;

    // DSP opcodes
    localparam logic [7:0] OP_DAC     = 8'h10;
    localparam logic [7:0] OP_DMA8    = 8'h14;
    localparam logic [7:0] OP_TC      = 8'h40;
    localparam logic [7:0] OP_PAUSE   = 8'hD0;
    localparam logic [7:0] OP_SPK_ON  = 8'hD1;
    localparam logic [7:0] OP_SPK_OFF = 8'hD3;
    localparam logic [7:0] OP_CONT    = 8'hD4;
    localparam logic [7:0] OP_VER     = 8'hE1;

    // 12800 cycles (TC=0 at 50 MHz) fits in 16 bits
    localparam int PACE_W = 16;
    typedef logic [PACE_W-1:0] pace_t;

    typedef enum logic [1:0] {P_IDLE, P_ARG1, P_ARG2} parse_e;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_REQ}  dma_e;
    typedef enum logic [1:0] {RS_DATA, RS_CMD, RS_STAT} rdsel_e;

    // Pacing reload: one sample period minus the cycle spent entering WAIT
    function automatic pace_t pace_load(input int clk_mhz, input logic [7:0] tc);
        int v;
        v = clk_mhz * (256 - int'(tc)) - 1;
        return pace_t'(v);
    endfunction

endpackage

// File: rtl/sb_dsp_dma_if.sv
// ISA-side and mixer-side signals of the DSP front end.
interface sb_dsp_dma_if;
    logic [9:0] io_addr;
    logic       aen;
    logic [7:0] io_wdata;
    logic       io_wr_stb;
    logic       io_rd_start;
    logic       io_rd_end;
    logic       dack_n;
    logic [7:0] io_rdata;
    logic       io_rdata_oe;
    logic       drq;
    logic       irq;
    logic [7:0] pcm_sample;
    logic       pcm_valid;
    logic       dma_active;

    modport slave (
        input  io_addr, aen, io_wdata, io_wr_stb, io_rd_start, io_rd_end, dack_n,
        output io_rdata, io_rdata_oe, drq, irq, pcm_sample, pcm_valid, dma_active
    );
    modport master (
        output io_addr, aen, io_wdata, io_wr_stb, io_rd_start, io_rd_end, dack_n,
        input  io_rdata, io_rdata_oe, drq, irq, pcm_sample, pcm_valid, dma_active
    );
endinterface

// File: rtl/sb_rd_queue.sv
// Byte FIFO behind the read-data port; flush may coincide with a push.
module sb_rd_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop, mem_we;
    logic [AW-1:0] mem_wa;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign mem_we  = flush ? push : do_push;
    assign mem_wa  = flush ? '0 : wr_ptr;
    assign dout    = mem[rd_ptr];

    // storage write, no reset needed
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push);
            cnt    <= (AW+1)'(push);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sb_dsp_dma.sv
// SB DSP front end: port decode, command parser, paced 8-bit DMA, IRQ.
module sb_dsp_dma
    import sb_pkg::*;
#(
    parameter logic [9:0] BASE     = 10'h220,
    parameter int         CLK_MHZ  = 50,
    parameter int         RQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    sb_dsp_dma_if.slave  bus
);
    localparam logic [9:0] A_RST  = BASE + 10'(OFF_RST);
    localparam logic [9:0] A_DATA = BASE + 10'(OFF_DATA);
    localparam logic [9:0] A_CMD  = BASE + 10'(OFF_CMD);
    localparam logic [9:0] A_STAT = BASE + 10'(OFF_STAT);

    parse_e      pstate;
    dma_e        dstate;
    rdsel_e      rd_sel, rd_kind;
    logic [7:0]  op, len_lo, tc, rdata, rd_val, pcm_sample, q_din, q_dout;
    logic [16:0] count;
    pace_t       pace;
    logic        paused, rst_armed, ver_pend, drq, irq, pcm_valid, dma_active, rd_oe;
    logic        cpu_sel, cpu_wr, wr_rst, wr_cmd, dack_wr, dsp_rst, rd_hit, stat_end;
    logic        q_push, q_pop, q_empty, q_full;

    // DACK cycles are DMA, never CPU I/O, whatever AEN says
    assign cpu_sel  = !bus.aen && bus.dack_n;
    assign cpu_wr   = bus.io_wr_stb && cpu_sel;
    assign wr_rst   = cpu_wr && (bus.io_addr == A_RST);
    assign wr_cmd   = cpu_wr && (bus.io_addr == A_CMD);
    assign dack_wr  = bus.io_wr_stb && !bus.dack_n;
    assign dsp_rst  = wr_rst && !bus.io_wdata[0] && rst_armed;
    assign q_pop    = bus.io_rd_end && rd_oe && (rd_sel == RS_DATA);
    assign stat_end = bus.io_rd_end && rd_oe && (rd_sel == RS_STAT);

    sb_rd_queue #(.DEPTH(RQ_DEPTH)) u_rq (
        .clk(clk), .rst(rst), .push(q_push), .pop(q_pop), .flush(dsp_rst),
        .din(q_din), .dout(q_dout), .empty(q_empty), .full(q_full)
    );

    // queue push source; version's second byte goes in the following cycle
    always_comb begin
        q_push = 1'b0;
        q_din  = 8'h00;
        if (dsp_rst) begin
            q_push = 1'b1; q_din = 8'hAA;
        end else if (ver_pend) begin
            q_push = 1'b1; q_din = 8'h01;
        end else if (wr_cmd && pstate == P_IDLE && bus.io_wdata == OP_VER) begin
            q_push = 1'b1; q_din = 8'h02;
        end
    end

    // read decode and the value presented for this read
    always_comb begin
        rd_hit  = 1'b0;
        rd_kind = RS_CMD;
        rd_val  = 8'h00;
        if (bus.io_rd_start && cpu_sel) begin
            if (bus.io_addr == A_DATA) begin
                rd_hit = 1'b1; rd_kind = RS_DATA; rd_val = q_empty ? 8'hFF : q_dout;
            end else if (bus.io_addr == A_CMD) begin
                rd_hit = 1'b1; rd_kind = RS_CMD;
            end else if (bus.io_addr == A_STAT) begin
                rd_hit = 1'b1; rd_kind = RS_STAT; rd_val = {!q_empty, 7'h7F};
            end
        end
    end

    // read data register and bus-drive window
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= 8'h00;
            rd_oe  <= 1'b0;
            rd_sel <= RS_DATA;
        end else if (rd_hit) begin
            rdata  <= rd_val;
            rd_oe  <= 1'b1;
            rd_sel <= rd_kind;
        end else if (bus.io_rd_end) begin
            rd_oe  <= 1'b0;
        end
    end

    // command parser, DMA engine and IRQ; DSP reset is applied last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate <= P_IDLE;  op <= 8'h00;  len_lo <= 8'h00;  tc <= 8'h00;
            paused <= 1'b0;    rst_armed <= 1'b0;  ver_pend <= 1'b0;
            dstate <= D_IDLE;  pace <= '0;  count <= '0;
            drq <= 1'b0;  irq <= 1'b0;  pcm_sample <= 8'h80;  pcm_valid <= 1'b0;
            dma_active <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            ver_pend  <= 1'b0;
            if (stat_end) irq <= 1'b0;

            case (dstate)
                D_WAIT: begin
                    if (pace != '0) pace <= pace - 1'b1;
                    else if (!paused && bus.dack_n) begin
                        dstate <= D_REQ;
                        drq    <= 1'b1;
                    end
                end
                D_REQ: begin
                    if (dack_wr) begin
                        pcm_sample <= bus.io_wdata;
                        pcm_valid  <= 1'b1;
                        drq        <= 1'b0;
                        count      <= count - 1'b1;
                        if (count == 17'd1) begin
                            irq        <= 1'b1;
                            dstate     <= D_IDLE;
                            dma_active <= 1'b0;
                        end else begin
                            pace   <= pace_load(CLK_MHZ, tc);
                            dstate <= D_WAIT;
                        end
                    end
                end
                default: ;
            endcase

            if (wr_rst) rst_armed <= bus.io_wdata[0];

            if (wr_cmd) begin
                case (pstate)
                    P_IDLE: begin
                        op <= bus.io_wdata;
                        case (bus.io_wdata)
                            OP_DAC, OP_DMA8, OP_TC: pstate <= P_ARG1;
                            OP_PAUSE:               paused <= 1'b1;
                            OP_CONT:                paused <= 1'b0;
                            OP_VER:                 ver_pend <= 1'b1;
                            OP_SPK_ON, OP_SPK_OFF:  ;
                            default:                ;
                        endcase
                    end
                    P_ARG1: begin
                        pstate <= P_IDLE;
                        case (op)
                            OP_DAC: begin
                                pcm_sample <= bus.io_wdata;
                                pcm_valid  <= 1'b1;
                            end
                            OP_DMA8: begin
                                len_lo <= bus.io_wdata;
                                pstate <= P_ARG2;
                            end
                            default: tc <= bus.io_wdata;
                        endcase
                    end
                    default: begin
                        // len_hi: a running transfer only gets its count replaced
                        pstate <= P_IDLE;
                        count  <= {1'b0, bus.io_wdata, len_lo} + 17'd1;
                        if (dstate == D_IDLE) begin
                            pace       <= pace_load(CLK_MHZ, tc);
                            dstate     <= D_WAIT;
                            dma_active <= 1'b1;
                        end
                    end
                endcase
            end

            if (dsp_rst) begin
                pstate <= P_IDLE;  dstate <= D_IDLE;  drq <= 1'b0;  dma_active <= 1'b0;
                irq <= 1'b0;  paused <= 1'b0;  ver_pend <= 1'b0;
            end
        end
    end

    assign bus.io_rdata    = rdata;
    assign bus.io_rdata_oe = rd_oe;
    assign bus.drq         = drq;
    assign bus.irq         = irq;
    assign bus.pcm_sample  = pcm_sample;
    assign bus.pcm_valid   = pcm_valid;
    assign bus.dma_active  = dma_active;
endmodule

// File: tb/tb_sb_dsp_dma.sv
// Scoreboard bench for sb_dsp_dma: expected reads and PCM bytes are queued
// at issue time and popped by monitors when the DUT presents them.
module tb_sb_dsp_dma;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sb_dsp_dma_if bus();
    sb_dsp_dma #(.BASE(10'h220), .CLK_MHZ(50), .RQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rq[$];        // model of the read queue
    logic [7:0] exp_rd[$];    // scoreboard: read data
    logic [7:0] exp_pcm[$];   // scoreboard: pcm bytes
    bit         irq_m = 0;
    logic       oe_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // read-data monitor: compares on the first cycle the DUT drives D
    always @(negedge clk) begin
        if (bus.io_rdata_oe && !oe_q) begin
            if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", bus.io_rdata, exp_rd.pop_front());
        end
        oe_q <= bus.io_rdata_oe;
    end

    // pcm monitor
    always @(negedge clk) begin
        if (bus.pcm_valid) begin
            if (exp_pcm.size() == 0) check("pcm_unexpected", 1, 0);
            else check("pcm_sample", bus.pcm_sample, exp_pcm.pop_front());
        end
    end

    function automatic void qpush(input logic [7:0] b);
        if (rq.size() < 4) rq.push_back(b);
    endfunction

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.io_addr = a; bus.io_wdata = d; bus.aen = 1'b0; bus.io_wr_stb = 1'b1;
        @(negedge clk);
        bus.io_wr_stb = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        if (a == 10'h22A) begin
            if (rq.size() == 0) exp_rd.push_back(8'hFF);
            else exp_rd.push_back(rq.pop_front());
        end else if (a == 10'h22E) begin
            exp_rd.push_back({rq.size() != 0, 7'h7F});
            irq_m = 0;
        end else exp_rd.push_back(8'h00);
        @(negedge clk);
        bus.io_addr = a; bus.aen = 1'b0; bus.io_rd_start = 1'b1;
        @(negedge clk);
        bus.io_rd_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.io_rd_end = 1'b1;
        @(negedge clk);
        bus.io_rd_end = 1'b0;
    endtask

    task automatic dsp_reset();
        wr(10'h226, 8'h01);
        wr(10'h226, 8'h00);
        rq.delete();
        rq.push_back(8'hAA);
        irq_m = 0;
    endtask

    task automatic version();
        wr(10'h22C, 8'hE1);
        qpush(8'h02);
        qpush(8'h01);
    endtask

    task automatic dac(input logic [7:0] b);
        wr(10'h22C, 8'h10);
        exp_pcm.push_back(b);
        wr(10'h22C, b);
    endtask

    task automatic dack(input logic [7:0] b, input bit expect_pcm);
        @(negedge clk);
        bus.dack_n = 1'b0; bus.aen = 1'b1; bus.io_addr = 10'($urandom);
        bus.io_wdata = b; bus.io_wr_stb = 1'b1;
        if (expect_pcm) exp_pcm.push_back(b);
        @(negedge clk);
        bus.io_wr_stb = 1'b0; bus.dack_n = 1'b1; bus.aen = 1'b0;
    endtask

    task automatic wait_drq(input int budget, output int c);
        c = 0;
        while (!bus.drq && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!bus.drq) check("drq_timeout", 0, 1);
    endtask

    task automatic start_dma(input logic [7:0] tc, input logic [15:0] len);
        wr(10'h22C, 8'h40); wr(10'h22C, tc);
        wr(10'h22C, 8'h14); wr(10'h22C, len[7:0]); wr(10'h22C, len[15:8]);
    endtask

    // complete transfer of len+1 bytes, each paced at 50*(256-tc) cycles
    task automatic dma_xfer(input logic [7:0] tc, input logic [15:0] len);
        int n, c;
        n = 50 * (256 - int'(tc));
        start_dma(tc, len);
        check("active_start", bus.dma_active, 1);
        for (int i = 0; i <= int'(len); i++) begin
            wait_drq(n + 20, c);
            check("pace", c, n);
            dack(8'($urandom), 1);
            check("drq_drop", bus.drq, 0);
        end
        irq_m = 1;
        check("irq_end", bus.irq, 1);
        check("active_end", bus.dma_active, 0);
    endtask

    initial begin
        int c, hold;
        bus.io_addr = '0; bus.aen = 1'b1; bus.io_wdata = '0; bus.io_wr_stb = 1'b0;
        bus.io_rd_start = 1'b0; bus.io_rd_end = 1'b0; bus.dack_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_rdata", bus.io_rdata, 8'h00);
        check("rst_oe", bus.io_rdata_oe, 0);
        check("rst_drq", bus.drq, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_pcm", bus.pcm_sample, 8'h80);
        check("rst_pcm_valid", bus.pcm_valid, 0);
        check("rst_active", bus.dma_active, 0);
        rd(10'h22A);
        rd(10'h22E);
        rd(10'h22C);

        // a lone 0 write to the reset port does nothing
        wr(10'h226, 8'h00);
        rd(10'h22E);

        // DSP reset sequence
        dsp_reset();
        rd(10'h22E); rd(10'h22A); rd(10'h22A); rd(10'h22E);

        // version, then overflow: AA,02,01,02 fill the queue, last 01 dropped
        version();
        rd(10'h22A); rd(10'h22A);
        dsp_reset();
        version(); version();
        repeat (5) rd(10'h22A);

        // direct DAC and an ignored opcode
        dac(8'h5C);
        wr(10'h22C, 8'h77);
        dac(8'hA3);

        // paced transfer with pause after byte 1
        start_dma(8'h9C, 16'h0003);
        wait_drq(6000, c);
        check("pace_first", c, 5000);
        dack(8'h11, 1);
        wr(10'h22C, 8'hD0);
        hold = 0;
        repeat (20000) begin
            @(negedge clk);
            if (bus.drq) hold++;
        end
        check("pause_hold", hold, 0);
        check("pause_active", bus.dma_active, 1);
        wr(10'h22C, 8'hD4);
        wait_drq(50, c);
        check("cont_prompt", c <= 2, 1);
        dack(8'h22, 1);
        wait_drq(6000, c);
        check("pace_3", c, 5000);
        dack(8'h33, 1);
        check("irq_mid", bus.irq, 0);
        wait_drq(6000, c);
        check("pace_4", c, 5000);
        dack(8'h44, 1);
        irq_m = 1;
        check("irq_after4", bus.irq, 1);
        check("active_after4", bus.dma_active, 0);
        rd(10'h22E);
        check("irq_cleared", bus.irq, 0);

        // len 0 gives exactly one byte; irq left set
        dma_xfer(8'hFF, 16'h0000);

        // len FFFF: still active after several bytes, stray DACK in WAIT ignored, then abort
        start_dma(8'hFF, 16'hFFFF);
        check("irq_survives_start", bus.irq, 1);
        wait_drq(100, c);
        dack(8'h01, 1);
        dack(8'hEE, 0);
        for (int i = 0; i < 3; i++) begin
            wait_drq(100, c);
            dack(8'(i + 2), 1);
            check("ffff_active", bus.dma_active, 1);
        end
        wait_drq(100, c);
        dsp_reset();
        check("abort_drq", bus.drq, 0);
        check("abort_active", bus.dma_active, 0);
        check("abort_irq", bus.irq, 0);
        rd(10'h22A);
        rd(10'h22E);

        // randomized mix against the model
        for (int it = 0; it < 30; it++) begin
            check("irq_model", bus.irq, irq_m);
            case ($urandom_range(0, 6))
                0: version();
                1: dac(8'($urandom));
                2: rd(10'h22A);
                3: rd(10'h22E);
                4: rd(10'h22C);
                5: dma_xfer(8'($urandom_range(250, 255)), 16'($urandom_range(0, 2)));
                default: dsp_reset();
            endcase
        end

        repeat (5) @(negedge clk);
        check("rd_left", exp_rd.size(), 0);
        check("pcm_left", exp_pcm.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
